// File: rtl/fp_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : fp_result_collector
// Brief    : In-order result FIFO for the pipelined FP multiplier, with issue
//            credits, sticky exception flags and a sticky protocol-error flag.
// Revision : 1.0 - initial release
// ============================================================================
module fp_result_collector #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic                   res_valid,
    input  logic [31:0]            res_data,
    input  logic                   res_overflow,
    input  logic                   res_underflow,
    input  logic                   res_inexact,
    input  logic                   res_invalid,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_data,
    output logic [3:0]             out_flags,
    output logic [3:0]             fflags,
    input  logic                   fflags_clr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   proto_err
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

    logic [35:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [c_CW-1:0] r_in_flight;
    logic [3:0]      r_fflags;
    logic            r_proto_err;

    logic            w_deq;
    logic            w_enq;
    logic            w_full;
    logic            w_drop;
    logic            w_orphan;
    logic            w_overissue;
    logic [35:0]     w_head;
    logic [c_CW:0]   w_committed;
    logic [c_CW-1:0] w_count_nxt;
    logic [c_CW-1:0] w_in_flight_nxt;
    logic [3:0]      w_fflags_nxt;

    assign w_head    = r_mem[r_rd_ptr];
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? w_head[31:0]  : '0;
    assign out_flags = out_valid ? w_head[35:32] : '0;

    // Credits consider only registered state, so a same-cycle dequeue frees a slot one cycle later.
    assign w_committed = {1'b0, r_in_flight} + {1'b0, r_count};
    assign issue_ready = (w_committed < {1'b0, c_DEPTH});

    assign w_full      = (r_count == c_DEPTH);
    assign w_deq       = out_valid & out_ready;
    assign w_enq       = res_valid & (~w_full | w_deq);
    assign w_drop      = res_valid & w_full & ~w_deq;
    assign w_orphan    = res_valid & (r_in_flight == '0);
    assign w_overissue = issue_valid & ~issue_ready;

    always_comb begin
        w_count_nxt = r_count;
        if (w_enq && !w_deq) begin
            w_count_nxt = r_count + c_CNT_ONE;
        end else if (!w_enq && w_deq) begin
            w_count_nxt = r_count - c_CNT_ONE;
        end
    end

    always_comb begin
        w_in_flight_nxt = r_in_flight;
        if (issue_valid && !res_valid && (r_in_flight != c_DEPTH)) begin
            w_in_flight_nxt = r_in_flight + c_CNT_ONE;
        end else if (res_valid && !issue_valid && (r_in_flight != '0)) begin
            w_in_flight_nxt = r_in_flight - c_CNT_ONE;
        end
    end

    // A clear coinciding with a retirement keeps the retiring flags.
    always_comb begin
        w_fflags_nxt = r_fflags;
        if (fflags_clr) begin
            w_fflags_nxt = w_deq ? w_head[35:32] : 4'b0000;
        end else if (w_deq) begin
            w_fflags_nxt = r_fflags | w_head[35:32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_in_flight <= '0;
            r_fflags    <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_enq) begin
                r_mem[r_wr_ptr] <= {res_invalid, res_overflow, res_underflow, res_inexact, res_data};
                r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count     <= w_count_nxt;
            r_in_flight <= w_in_flight_nxt;
            r_fflags    <= w_fflags_nxt;
            if (w_overissue || w_orphan || w_drop) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign count     = r_count;
    assign fflags    = r_fflags;
    assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_fp_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_result_collector
// Brief    : Self-checking bench for fp_result_collector against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_result_collector;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          issue_valid = 1'b0;
    logic          issue_ready;
    logic          res_valid = 1'b0;
    logic [31:0]   res_data = '0;
    logic [3:0]    res_flags = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_data;
    logic [3:0]    out_flags;
    logic [3:0]    fflags;
    logic          fflags_clr = 1'b0;
    logic [CW-1:0] count;
    logic          proto_err;

    fp_result_collector #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_overflow (res_flags[2]),
        .res_underflow(res_flags[1]),
        .res_inexact  (res_flags[0]),
        .res_invalid  (res_flags[3]),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_flags    (out_flags),
        .fflags       (fflags),
        .fflags_clr   (fflags_clr),
        .count        (count),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Reference state: queue of {flags, data}, outstanding ops, sticky bits.
    logic [35:0] mq[$];
    int          m_inf = 0;
    logic [3:0]  m_ff = '0;
    bit          m_perr = 1'b0;
    logic [35:0] cmp_head;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return (m_inf + mq.size()) < DEPTH;
    endfunction

    task automatic model_step();
        bit          deq;
        bit          drop;
        logic [35:0] head;
        deq  = (mq.size() != 0) && out_ready;
        head = deq ? mq[0] : '0;
        drop = res_valid && (mq.size() == DEPTH) && !deq;
        if ((issue_valid && !m_ready()) || (res_valid && m_inf == 0) || drop) m_perr = 1'b1;
        if (issue_valid && !res_valid) m_inf = (m_inf < DEPTH) ? m_inf + 1 : DEPTH;
        else if (res_valid && !issue_valid && m_inf > 0) m_inf--;
        if (deq) void'(mq.pop_front());
        if (res_valid && !drop) mq.push_back({res_flags, res_data});
        m_ff = fflags_clr ? head[35:32] : (m_ff | head[35:32]);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_head = (mq.size() != 0) ? mq[0] : '0;
            check("out_valid",   out_valid,   mq.size() != 0);
            check("out_data",    out_data,    cmp_head[31:0]);
            check("out_flags",   out_flags,   cmp_head[35:32]);
            check("count",       count,       mq.size());
            check("issue_ready", issue_ready, m_ready());
            check("fflags",      fflags,      m_ff);
            check("proto_err",   proto_err,   m_perr);
        end
    end

    task automatic step(input bit iv, input bit rv, input logic [31:0] d,
                        input logic [3:0] f, input bit ordy, input bit clr);
        issue_valid = iv;
        res_valid   = rv;
        res_data    = d;
        res_flags   = f;
        out_ready   = ordy;
        fflags_clr  = clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        chk_en      = 1'b0;
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        res_valid   = 1'b0;
        out_ready   = 1'b0;
        fflags_clr  = 1'b0;
        mq.delete();
        m_inf  = 0;
        m_ff   = '0;
        m_perr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic fill_full(input logic [31:0] base);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, base + i, 4'(i), 0, 0);
    endtask

    initial begin
        apply_reset();
        check("rst_out_valid",   out_valid,   0);
        check("rst_out_data",    out_data,    0);
        check("rst_count",       count,       0);
        check("rst_issue_ready", issue_ready, 1);
        check("rst_fflags",      fflags,      0);
        check("rst_proto_err",   proto_err,   0);

        // Single operation with four-cycle latency
        step(1, 0, 0, 0, 1, 0);
        repeat (3) step(0, 0, 0, 0, 1, 0);
        step(0, 1, 32'h40C00000, 4'b0000, 1, 0);
        check("single_valid", out_valid, 1);
        check("single_data",  out_data,  32'h40C00000);
        step(0, 0, 0, 0, 1, 0);
        check("single_once",   out_valid, 0);
        check("single_fflags", fflags,    0);

        // Credit exhaustion
        for (int i = 0; i < DEPTH - 1; i++) step(1, 0, 0, 0, 0, 0);
        check("credit_7_ready", issue_ready, 1);
        step(1, 0, 0, 0, 0, 0);
        check("credit_8_ready", issue_ready, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 32'h100 + i, 0, 0, 0);
        check("credit_count8", count, 8);
        step(0, 0, 0, 0, 1, 0);
        check("credit_ready_back", issue_ready, 1);
        check("credit_second",     out_data,    32'h101);
        repeat (DEPTH - 1) step(0, 0, 0, 0, 1, 0);
        check("credit_drained", out_valid, 0);

        // Sticky flag accumulation and clear
        repeat (3) step(1, 0, 0, 0, 0, 0);
        step(0, 1, 32'h1, 4'b0001, 0, 0);
        step(0, 1, 32'h2, 4'b0100, 0, 0);
        step(0, 1, 32'h3, 4'b1000, 0, 0);
        repeat (3) step(0, 0, 0, 0, 1, 0);
        check("flags_acc", fflags, 4'b1101);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 32'h4, 4'b0010, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        check("flags_clr_set", fflags, 4'b0010);
        step(0, 0, 0, 0, 0, 1);
        check("flags_clr_only", fflags, 4'b0000);

        // Streaming 20 results across pointer wrap
        for (int i = 0; i < 20; i++) step(1, i > 0, 32'h200 + i, 4'(i), 1, 0);
        step(0, 1, 32'h214, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        check("wrap_perr", proto_err, 0);

        // Full with simultaneous enqueue and dequeue
        fill_full(32'h300);
        step(0, 1, 32'hABCD, 4'b0101, 1, 0);
        check("fullsim_count", count,    8);
        check("fullsim_head",  out_data, 32'h301);
        repeat (DEPTH) step(0, 0, 0, 0, 1, 0);

        // Protocol errors
        apply_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 0, 0);
        check("overissue_pre", proto_err, 0);
        step(1, 0, 0, 0, 0, 0);
        check("overissue_err", proto_err, 1);

        apply_reset();
        step(0, 1, 32'h55, 0, 0, 0);
        check("orphan_err",   proto_err, 1);
        check("orphan_count", count,     1);
        check("orphan_data",  out_data,  32'h55);

        apply_reset();
        fill_full(32'h400);
        step(0, 1, 32'hDEAD, 0, 0, 0);
        check("drop_count", count,     8);
        check("drop_err",   proto_err, 1);
        repeat (DEPTH + 1) step(0, 0, 0, 0, 1, 0);

        // Asynchronous reset mid-stream
        apply_reset();
        repeat (5) step(1, 0, 0, 0, 0, 0);
        step(0, 1, 32'h10, 4'b1111, 0, 0);
        step(0, 1, 32'h11, 4'b0001, 0, 0);
        step(0, 1, 32'h12, 4'b0010, 1, 0);
        check("mid_count", count, 2);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("mid_out_valid",   out_valid,   0);
        check("mid_out_data",    out_data,    0);
        check("mid_out_flags",   out_flags,   0);
        check("mid_count0",      count,       0);
        check("mid_issue_ready", issue_ready, 1);
        check("mid_fflags",      fflags,      0);
        check("mid_proto_err",   proto_err,   0);

        // Randomized legal traffic with alternating backpressure
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            bit iv, rv, ordy;
            iv   = m_ready() && ($urandom % 2 == 0);
            rv   = (m_inf > 0) && ($urandom % 3 != 0);
            ordy = ((c / 100) % 2 == 1) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
            step(iv, rv, $urandom, 4'($urandom), ordy, $urandom % 16 == 0);
        end
        check("rand_legal_perr", proto_err, 0);

        // Randomized unconstrained traffic, including protocol violations
        for (int c = 0; c < 500; c++) begin
            step($urandom % 2 == 0, $urandom % 2 == 0, $urandom, 4'($urandom),
                 $urandom % 3 == 0, $urandom % 16 == 0);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
